// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes: physical tag width, register counts
// and the pointer type used by the free list.
package rename_pkg;
  localparam int unsigned PHY_W    = 6;
  localparam int unsigned NUM_PHY  = 64;
  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned PTR_W    = PHY_W + 1;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned FREE_W   = PHY_W + 1;

  typedef logic [PHY_W-1:0] phy_tag_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;

  localparam phy_tag_t PHY_NONE = 6'd0;
endpackage

// File: rtl/phy_free_list_if.sv
// Rename/commit side bundle of the physical-register free list.
interface phy_free_list_if;
  import rename_pkg::*;

  logic                flush;
  logic                Stall;
  logic                Inst1_Need, Inst2_Need, Inst3_Need, Inst4_Need;
  phy_tag_t            Inst1_Phydst, Inst2_Phydst, Inst3_Phydst, Inst4_Phydst;
  logic                Free_Stall;
  logic                Ret1_Valid, Ret2_Valid, Ret3_Valid, Ret4_Valid;
  phy_tag_t            Ret1_Phyreg, Ret2_Phyreg, Ret3_Phyreg, Ret4_Phyreg;
  logic [CNT_W-1:0]    Commit_Alloc_Num;
  logic [FREE_W-1:0]   Free_Num;

  modport master (
    output flush, Stall,
    output Inst1_Need, Inst2_Need, Inst3_Need, Inst4_Need,
    output Ret1_Valid, Ret2_Valid, Ret3_Valid, Ret4_Valid,
    output Ret1_Phyreg, Ret2_Phyreg, Ret3_Phyreg, Ret4_Phyreg,
    output Commit_Alloc_Num,
    input  Inst1_Phydst, Inst2_Phydst, Inst3_Phydst, Inst4_Phydst,
    input  Free_Stall, Free_Num
  );

  modport slave (
    input  flush, Stall,
    input  Inst1_Need, Inst2_Need, Inst3_Need, Inst4_Need,
    input  Ret1_Valid, Ret2_Valid, Ret3_Valid, Ret4_Valid,
    input  Ret1_Phyreg, Ret2_Phyreg, Ret3_Phyreg, Ret4_Phyreg,
    input  Commit_Alloc_Num,
    output Inst1_Phydst, Inst2_Phydst, Inst3_Phydst, Inst4_Phydst,
    output Free_Stall, Free_Num
  );
endinterface

// File: rtl/popcount4_prefix.sv
// Exclusive prefix counts and total of four request bits; slot k's offset
// is the number of set bits in slots below it.
module popcount4_prefix (
  input  logic [3:0]      req,
  output logic [3:0][1:0] prefix,
  output logic [2:0]      total
);
  always_comb begin
    prefix    = '0;
    prefix[1] = 2'(req[0]);
    prefix[2] = 2'(req[0]) + 2'(req[1]);
    prefix[3] = 2'(req[0]) + 2'(req[1]) + 2'(req[2]);
    total     = 3'(prefix[3]) + 3'(req[3]);
  end
endmodule

// File: rtl/phy_free_list.sv
// Circular free list of physical tags with a commit head so a flush can
// return every speculatively allocated tag in one cycle.
module phy_free_list
  import rename_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  phy_free_list_if.slave  bus
);
  phy_tag_t          fl [NUM_PHY];
  fl_ptr_t           head, commit_head, tail;
  logic [3:0]        need, rel;
  phy_tag_t          ret_tag [4];
  logic [3:0][1:0]   need_pre, rel_pre;
  logic [2:0]        req, rel_cnt;
  logic [FREE_W-1:0] free_num;
  logic              free_stall, fire;
  phy_tag_t          alloc_idx [4];
  phy_tag_t          rel_idx [4];
  phy_tag_t          tag [4];
  fl_ptr_t           commit_next;

  assign need       = {bus.Inst4_Need, bus.Inst3_Need, bus.Inst2_Need, bus.Inst1_Need};
  assign ret_tag[0] = bus.Ret1_Phyreg;
  assign ret_tag[1] = bus.Ret2_Phyreg;
  assign ret_tag[2] = bus.Ret3_Phyreg;
  assign ret_tag[3] = bus.Ret4_Phyreg;
  // Tag 0 is r0 forever and must never re-enter the list.
  assign rel = {bus.Ret4_Valid && (ret_tag[3] != PHY_NONE),
                bus.Ret3_Valid && (ret_tag[2] != PHY_NONE),
                bus.Ret2_Valid && (ret_tag[1] != PHY_NONE),
                bus.Ret1_Valid && (ret_tag[0] != PHY_NONE)};

  popcount4_prefix u_alloc_cnt (.req(need), .prefix(need_pre), .total(req));
  popcount4_prefix u_rel_cnt   (.req(rel),  .prefix(rel_pre),  .total(rel_cnt));

  assign free_num    = tail - head;
  assign free_stall  = FREE_W'(req) > free_num;
  assign fire        = !rst && !bus.flush && !bus.Stall && !free_stall;
  assign commit_next = commit_head + PTR_W'(bus.Commit_Alloc_Num);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      alloc_idx[k] = head[PHY_W-1:0] + PHY_W'(need_pre[k]);
      rel_idx[k]   = tail[PHY_W-1:0] + PHY_W'(rel_pre[k]);
      tag[k]       = need[k] ? fl[alloc_idx[k]] : PHY_NONE;
    end
  end

  assign bus.Inst1_Phydst = tag[0];
  assign bus.Inst2_Phydst = tag[1];
  assign bus.Inst3_Phydst = tag[2];
  assign bus.Inst4_Phydst = tag[3];
  assign bus.Free_Stall   = free_stall;
  assign bus.Free_Num     = free_num;

  // Releases are written behind tail with no same-cycle bypass to allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= PTR_W'(NUM_ARCH);
      for (int i = 0; i < NUM_PHY; i++)
        fl[i] <= (i < NUM_ARCH) ? PHY_W'(NUM_ARCH + i) : PHY_NONE;
    end else begin
      commit_head <= commit_next;
      if (bus.flush)
        head <= commit_next;
      else if (fire)
        head <= head + PTR_W'(req);
      tail <= tail + PTR_W'(rel_cnt);
      for (int k = 0; k < 4; k++)
        if (rel[k]) fl[rel_idx[k]] <= ret_tag[k];
    end
  end

  free_num_bound: assert property (@(posedge clk) disable iff (rst)
                                   free_num <= FREE_W'(NUM_PHY));
endmodule
